reg_xfer_seq: RTL and testbench

Register-transfer sequencer with a small integrated ALU. It sits directly upstream of the register file and drives that file's active-low output-enable and load strobes. Each accepted command reads one or two source registers off aBus, computes a 16-bit result, and writes it back over yBus into a destination register (r0-r6 or PC=7). Commands arrive from the control unit over a valid/ready handshake.

---
 rtl/reg_xfer_seq.sv | 222 ++++++++++++++++++++++
 tb/tb_reg_xfer_seq.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_xfer_seq.sv
// Register-transfer sequencer: reads one or two registers off aBus, runs the ALU, writes back over yBus.
// Optional build macro REG_XFER_PCINC_EN requests a PC increment during non-PC write-backs.
module reg_xfer_seq #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned NREG  = 8
) (
  input  logic             clock,
  input  logic             notReset,
  input  logic             cmdValid,
  output logic             cmdReady,
  input  logic [3:0]       cmdOp,
  input  logic [2:0]       cmdSrcA,
  input  logic [2:0]       cmdSrcB,
  input  logic [2:0]       cmdDst,
  input  logic [WIDTH-1:0] aBus,
  inout  wire  [WIDTH-1:0] yBus,
  output logic [NREG-1:0]  notOE,
  output logic [NREG-1:0]  notLoad,
  output logic             pcInc,
  output logic             done,
  output logic             flagC,
  output logic             flagZ
);

  localparam logic [3:0] OP_ADD = 4'd1;
  localparam logic [3:0] OP_SUB = 4'd2;
  localparam logic [3:0] OP_AND = 4'd3;
  localparam logic [3:0] OP_OR  = 4'd4;
  localparam logic [3:0] OP_XOR = 4'd5;
  localparam logic [3:0] OP_NOT = 4'd6;
  localparam logic [3:0] OP_SHL = 4'd7;
  localparam logic [3:0] OP_SHR = 4'd8;
  localparam logic [3:0] OP_ADC = 4'd9;
  localparam logic [2:0] PC_IDX = 3'(NREG - 1);

`ifdef REG_XFER_PCINC_EN
  localparam bit PCINC_EN = 1'b1;
`else
  localparam bit PCINC_EN = 1'b0;
`endif

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_READ_A = 2'd1,
    S_READ_B = 2'd2,
    S_WRITE  = 2'd3
  } state_t;

  state_t           r_state, w_state_n;
  logic [3:0]       r_op;
  logic [2:0]       r_src_b, r_dst;
  logic [WIDTH-1:0] r_tmp_a, r_tmp_b;
  logic             r_flag_c, r_flag_z;
  logic             r_ready, r_done, r_pc_inc, r_y_en;
  logic [NREG-1:0]  r_not_oe, r_not_load;

  logic             w_ready_n, w_done_n, w_pc_inc_n, w_y_en_n;
  logic [NREG-1:0]  w_not_oe_n, w_not_load_n;
  logic             w_latch, w_cap_a, w_cap_b, w_flag_we, w_enter_write;
  logic             w_binary;
  logic [WIDTH-1:0] w_result;
  logic [WIDTH:0]   w_sum;
  logic             w_c_n, w_z_n, w_z_upd;

  // Ops that need a second operand read
  always_comb begin
    w_binary = 1'b0;
    case (r_op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_ADC: w_binary = 1'b1;
      default:                                       w_binary = 1'b0;
    endcase
  end

  // ALU on latched operands; reserved codes fall through as MOV with flags held
  always_comb begin
    w_result = r_tmp_a;
    w_sum    = '0;
    w_c_n    = r_flag_c;
    w_z_upd  = 1'b1;
    case (r_op)
      OP_ADD: begin
        w_sum    = {1'b0, r_tmp_a} + {1'b0, r_tmp_b};
        w_result = w_sum[WIDTH-1:0];
        w_c_n    = w_sum[WIDTH];
      end
      OP_SUB: begin
        w_sum    = {1'b0, r_tmp_a} - {1'b0, r_tmp_b};
        w_result = w_sum[WIDTH-1:0];
        w_c_n    = w_sum[WIDTH];
      end
      OP_AND: begin w_result = r_tmp_a & r_tmp_b; w_c_n = 1'b0; end
      OP_OR:  begin w_result = r_tmp_a | r_tmp_b; w_c_n = 1'b0; end
      OP_XOR: begin w_result = r_tmp_a ^ r_tmp_b; w_c_n = 1'b0; end
      OP_NOT: begin w_result = ~r_tmp_a;          w_c_n = 1'b0; end
      OP_SHL: begin
        w_result = {r_tmp_a[WIDTH-2:0], 1'b0};
        w_c_n    = r_tmp_a[WIDTH-1];
      end
      OP_SHR: begin
        w_result = {1'b0, r_tmp_a[WIDTH-1:1]};
        w_c_n    = r_tmp_a[0];
      end
      OP_ADC: begin
        w_sum    = {1'b0, r_tmp_a} + {1'b0, r_tmp_b} + {{WIDTH{1'b0}}, r_flag_c};
        w_result = w_sum[WIDTH-1:0];
        w_c_n    = w_sum[WIDTH];
      end
      default: w_z_upd = 1'b0;
    endcase
  end

  assign w_z_n = w_z_upd ? (w_result == '0) : r_flag_z;

  // Next-state and next-strobe decode; strobes for the next cycle are registered
  always_comb begin
    w_state_n     = r_state;
    w_ready_n     = 1'b0;
    w_not_oe_n    = '1;
    w_not_load_n  = '1;
    w_done_n      = 1'b0;
    w_pc_inc_n    = 1'b0;
    w_y_en_n      = 1'b0;
    w_latch       = 1'b0;
    w_cap_a       = 1'b0;
    w_cap_b       = 1'b0;
    w_flag_we     = 1'b0;
    w_enter_write = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (cmdValid) begin
          w_latch    = 1'b1;
          w_state_n  = S_READ_A;
          w_not_oe_n = ~(NREG'(1) << cmdSrcA);
        end else begin
          w_ready_n  = 1'b1;
        end
      end
      S_READ_A: begin
        w_cap_a = 1'b1;
        if (w_binary) begin
          w_state_n  = S_READ_B;
          w_not_oe_n = ~(NREG'(1) << r_src_b);
        end else begin
          w_state_n     = S_WRITE;
          w_enter_write = 1'b1;
        end
      end
      S_READ_B: begin
        w_cap_b       = 1'b1;
        w_state_n     = S_WRITE;
        w_enter_write = 1'b1;
      end
      S_WRITE: begin
        w_flag_we = 1'b1;
        w_state_n = S_IDLE;
        w_ready_n = 1'b1;
      end
      default: begin
        w_state_n = S_IDLE;
        w_ready_n = 1'b1;
      end
    endcase
    if (w_enter_write) begin
      w_not_load_n = ~(NREG'(1) << r_dst);
      w_done_n     = 1'b1;
      w_y_en_n     = 1'b1;
      w_pc_inc_n   = PCINC_EN && (r_dst != PC_IDX);
    end
  end

  always_ff @(posedge clock or negedge notReset) begin
    if (!notReset) r_state <= S_IDLE;
    else           r_state <= w_state_n;
  end

  // Registered strobes, latched command, operands and flags
  always_ff @(posedge clock or negedge notReset) begin
    if (!notReset) begin
      r_ready    <= 1'b1;
      r_done     <= 1'b0;
      r_pc_inc   <= 1'b0;
      r_y_en     <= 1'b0;
      r_not_oe   <= '1;
      r_not_load <= '1;
      r_op       <= '0;
      r_src_b    <= '0;
      r_dst      <= '0;
      r_tmp_a    <= '0;
      r_tmp_b    <= '0;
      r_flag_c   <= 1'b0;
      r_flag_z   <= 1'b0;
    end else begin
      r_ready    <= w_ready_n;
      r_done     <= w_done_n;
      r_pc_inc   <= w_pc_inc_n;
      r_y_en     <= w_y_en_n;
      r_not_oe   <= w_not_oe_n;
      r_not_load <= w_not_load_n;
      if (w_latch) begin
        r_op    <= cmdOp;
        r_src_b <= cmdSrcB;
        r_dst   <= cmdDst;
      end
      if (w_cap_a) r_tmp_a <= aBus;
      if (w_cap_b) r_tmp_b <= aBus;
      if (w_flag_we) begin
        r_flag_c <= w_c_n;
        r_flag_z <= w_z_n;
      end
    end
  end

  assign yBus     = r_y_en ? w_result : 'z;
  assign cmdReady = r_ready;
  assign done     = r_done;
  assign pcInc    = r_pc_inc;
  assign notOE    = r_not_oe;
  assign notLoad  = r_not_load;
  assign flagC    = r_flag_c;
  assign flagZ    = r_flag_z;

endmodule

// File: tb/tb_reg_xfer_seq.sv
// Bench for reg_xfer_seq: register-file model on aBus/yBus, directed vector table, reset/throughput cases, random ops.
`timescale 1ns/1ps
module tb_reg_xfer_seq;

`ifdef REG_XFER_PCINC_EN
  localparam bit PCEN = 1'b1;
`else
  localparam bit PCEN = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        notReset = 1'b0;
  logic        cmdValid = 1'b0;
  logic        cmdReady;
  logic [3:0]  cmdOp = '0;
  logic [2:0]  cmdSrcA = '0, cmdSrcB = '0, cmdDst = '0;
  logic [15:0] aBus;
  wire  [15:0] yBus;
  logic [7:0]  notOE, notLoad;
  logic        pcInc, done, flagC, flagZ;

  reg_xfer_seq dut (
    .clock(clock), .notReset(notReset), .cmdValid(cmdValid), .cmdReady(cmdReady),
    .cmdOp(cmdOp), .cmdSrcA(cmdSrcA), .cmdSrcB(cmdSrcB), .cmdDst(cmdDst),
    .aBus(aBus), .yBus(yBus), .notOE(notOE), .notLoad(notLoad),
    .pcInc(pcInc), .done(done), .flagC(flagC), .flagZ(flagZ)
  );

  always #5 clock = ~clock;

  // Register file environment: output-enable drives aBus, load strobe captures yBus
  logic [15:0] regs [0:7];
  logic        pl_en = 1'b0;
  logic [2:0]  pl_idx = '0;
  logic [15:0] pl_val = '0;

  always_comb begin
    aBus = '0;
    for (int i = 0; i < 8; i++) if (!notOE[i]) aBus = regs[i];
  end

  always @(posedge clock) begin
    if (pl_en) regs[pl_idx] <= pl_val;
    else for (int i = 0; i < 8; i++) if (!notLoad[i]) regs[i] <= yBus;
  end

  int n_cmp = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic preload(input logic [2:0] idx, input logic [15:0] val);
    @(negedge clock);
    pl_en = 1'b1; pl_idx = idx; pl_val = val;
    @(negedge clock);
    pl_en = 1'b0;
  endtask

  function automatic bit is_binary(input logic [3:0] op);
    return (op >= 4'd1 && op <= 4'd5) || op == 4'd9;
  endfunction

  // Reference ALU in plain integer arithmetic
  function automatic void ref_alu(input int op, input int a, input int b,
                                  inout bit c, inout bit z, output int y);
    int s;
    bit upd;
    upd = 1'b1;
    y = a;
    case (op)
      1: begin s = a + b; y = s % 65536; c = (s >= 65536); end
      2: begin y = (a - b + 65536) % 65536; c = (a < b); end
      3: begin y = a & b; c = 1'b0; end
      4: begin y = a | b; c = 1'b0; end
      5: begin y = a ^ b; c = 1'b0; end
      6: begin y = 65535 - a; c = 1'b0; end
      7: begin y = (a * 2) % 65536; c = (a >= 32768); end
      8: begin y = a / 2; c = (a % 2) == 1; end
      9: begin s = a + b + int'(c); y = s % 65536; c = (s >= 65536); end
      default: upd = 1'b0;
    endcase
    if (upd) z = (y == 0);
  endfunction

  logic [7:0]  tr_oe [0:15];
  logic [7:0]  tr_load [0:15];
  logic        tr_pc [0:15];
  int          t_cyc, t_done_cnt;
  logic [15:0] t_y;
  logic        t_bad, t_done_after, t_ready_after;

  // Issue one command; keep cmdValid high with junk while busy, it must be ignored
  task automatic run_cmd(input logic [3:0] op, input logic [2:0] sa, input logic [2:0] sb, input logic [2:0] d);
    int n;
    t_cyc = 0; t_done_cnt = 0; t_bad = 1'b0; t_y = '0;
    for (int k = 0; k < 16; k++) begin tr_oe[k] = '1; tr_load[k] = '1; tr_pc[k] = 1'b0; end
    @(negedge clock);
    cmdValid = 1'b1; cmdOp = op; cmdSrcA = sa; cmdSrcB = sb; cmdDst = d;
    n = 0;
    while (!cmdReady && n < 20) begin @(negedge clock); n++; end
    chk("accept_ready", 32'(cmdReady), 32'd1);
    @(posedge clock);
    for (int k = 1; k <= 8; k++) begin
      @(negedge clock);
      if (k == 1) begin
        cmdOp = 4'($urandom); cmdSrcA = 3'($urandom); cmdSrcB = 3'($urandom); cmdDst = 3'($urandom);
      end
      tr_oe[k] = notOE; tr_load[k] = notLoad; tr_pc[k] = pcInc;
      if ($countones(~notOE) > 1 || $countones(~notLoad) > 1) t_bad = 1'b1;
      if (done) begin t_done_cnt++; t_cyc = k; t_y = yBus; break; end
    end
    @(negedge clock);
    cmdValid = 1'b0;
    t_done_after = done; t_ready_after = cmdReady;
  endtask

  task automatic do_check(input string nm, input logic [3:0] op, input logic [2:0] sa, input logic [2:0] sb,
                          input logic [2:0] d, input logic [15:0] ey, input logic ec, input logic ez);
    logic [7:0] e_oe_a, e_oe_b, e_load;
    logic       pc_other, e_pc;
    bit         bin;
    bin    = is_binary(op);
    e_oe_a = ~(8'h01 << sa);
    e_oe_b = ~(8'h01 << sb);
    e_load = ~(8'h01 << d);
    e_pc   = PCEN && (d != 3'd7);
    run_cmd(op, sa, sb, d);
    chk({nm, " cycles"}, 32'(t_cyc), bin ? 32'd3 : 32'd2);
    chk({nm, " oeA"}, 32'(tr_oe[1]), 32'(e_oe_a));
    if (bin) chk({nm, " oeB"}, 32'(tr_oe[2]), 32'(e_oe_b));
    chk({nm, " loadA"}, 32'(tr_load[1]), 32'hFF);
    chk({nm, " oeW"}, 32'(tr_oe[t_cyc]), 32'hFF);
    chk({nm, " load"}, 32'(tr_load[t_cyc]), 32'(e_load));
    chk({nm, " yBus"}, 32'(t_y), 32'(ey));
    chk({nm, " reg"}, 32'(regs[d]), 32'(ey));
    chk({nm, " flagC"}, 32'(flagC), 32'(ec));
    chk({nm, " flagZ"}, 32'(flagZ), 32'(ez));
    chk({nm, " done_cnt"}, 32'(t_done_cnt), 32'd1);
    chk({nm, " done_after"}, 32'(t_done_after), 32'd0);
    chk({nm, " ready_after"}, 32'(t_ready_after), 32'd1);
    chk({nm, " onehot"}, 32'(t_bad), 32'd0);
    pc_other = 1'b0;
    for (int k = 1; k < t_cyc; k++) pc_other |= tr_pc[k];
    chk({nm, " pcW"}, 32'(tr_pc[t_cyc]), 32'(e_pc));
    chk({nm, " pcO"}, 32'(pc_other), 32'd0);
  endtask

  typedef struct {
    logic [3:0]  op;
    logic [2:0]  sa, sb, d;
    logic [15:0] va, vb, ey;
    logic        ec, ez;
  } vec_t;

  vec_t        tbl [16];
  logic [15:0] mr [0:7];
  bit          mc, mz;

  function automatic logic [15:0] rnd_val();
    case ($urandom_range(0, 4))
      0:       return 16'h0000;
      1:       return 16'hFFFF;
      2:       return 16'h8000;
      default: return 16'($urandom);
    endcase
  endfunction

  initial begin
    int acc [0:3];
    int na;
    logic [3:0] op;
    logic [2:0] sa, sb, d;
    int y;
    bit c2, z2;

    // Flags evolve row to row, so expected C/Z are computed along the sequence
    tbl[0]  = '{4'd1,  3'd1, 3'd2, 3'd3, 16'h0003, 16'h0005, 16'h0008, 1'b0, 1'b0};
    tbl[1]  = '{4'd1,  3'd1, 3'd2, 3'd1, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b1};
    tbl[2]  = '{4'd9,  3'd2, 3'd2, 3'd4, 16'h0001, 16'h0001, 16'h0003, 1'b0, 1'b0};
    tbl[3]  = '{4'd2,  3'd5, 3'd6, 3'd0, 16'h0002, 16'h0003, 16'hFFFF, 1'b1, 1'b0};
    tbl[4]  = '{4'd0,  3'd0, 3'd0, 3'd7, 16'hFFFF, 16'hFFFF, 16'hFFFF, 1'b1, 1'b0};
    tbl[5]  = '{4'd7,  3'd1, 3'd1, 3'd1, 16'h8001, 16'h8001, 16'h0002, 1'b1, 1'b0};
    tbl[6]  = '{4'd8,  3'd1, 3'd1, 3'd1, 16'h0002, 16'h0002, 16'h0001, 1'b0, 1'b0};
    tbl[7]  = '{4'd12, 3'd1, 3'd1, 3'd2, 16'h0001, 16'h0001, 16'h0001, 1'b0, 1'b0};
    tbl[8]  = '{4'd5,  3'd3, 3'd3, 3'd5, 16'h1234, 16'h1234, 16'h0000, 1'b0, 1'b1};
    tbl[9]  = '{4'd10, 3'd3, 3'd3, 3'd6, 16'h00AA, 16'h00AA, 16'h00AA, 1'b0, 1'b1};
    tbl[10] = '{4'd7,  3'd6, 3'd6, 3'd2, 16'hC000, 16'hC000, 16'h8000, 1'b1, 1'b0};
    tbl[11] = '{4'd3,  3'd4, 3'd5, 3'd0, 16'hFF00, 16'h0F0F, 16'h0F00, 1'b0, 1'b0};
    tbl[12] = '{4'd6,  3'd7, 3'd7, 3'd1, 16'hFFFF, 16'hFFFF, 16'h0000, 1'b0, 1'b1};
    tbl[13] = '{4'd4,  3'd2, 3'd3, 3'd7, 16'h0F00, 16'h00F0, 16'h0FF0, 1'b0, 1'b0};
    tbl[14] = '{4'd2,  3'd2, 3'd2, 3'd2, 16'h0005, 16'h0005, 16'h0000, 1'b0, 1'b1};
    tbl[15] = '{4'd1,  3'd3, 3'd4, 3'd5, 16'h8000, 16'h8000, 16'h0000, 1'b1, 1'b1};

    repeat (2) @(negedge clock);
    chk("rst notOE", 32'(notOE), 32'hFF);
    chk("rst notLoad", 32'(notLoad), 32'hFF);
    chk("rst flags", 32'({flagC, flagZ}), 32'd0);
    chk("rst done_pc", 32'({done, pcInc}), 32'd0);
    notReset = 1'b1;
    @(negedge clock);
    chk("rst ready", 32'(cmdReady), 32'd1);

    for (int i = 0; i < 16; i++) begin
      preload(tbl[i].sa, tbl[i].va);
      if (tbl[i].sb != tbl[i].sa) preload(tbl[i].sb, tbl[i].vb);
      do_check($sformatf("row%0d", i), tbl[i].op, tbl[i].sa, tbl[i].sb, tbl[i].d, tbl[i].ey, tbl[i].ec, tbl[i].ez);
    end

    // Reset in the middle of READ_B of an ADD aborts with no write-back
    preload(3'd1, 16'h0003); preload(3'd2, 16'h0004); preload(3'd3, 16'h5555);
    @(negedge clock);
    cmdValid = 1'b1; cmdOp = 4'd1; cmdSrcA = 3'd1; cmdSrcB = 3'd2; cmdDst = 3'd3;
    na = 0;
    while (!cmdReady && na < 20) begin @(negedge clock); na++; end
    @(posedge clock);
    @(negedge clock);
    cmdValid = 1'b0;
    @(posedge clock);
    #2;
    chk("mid oeB", 32'(notOE), 32'hFB);
    notReset = 1'b0;
    #1;
    chk("abort notOE", 32'(notOE), 32'hFF);
    chk("abort notLoad", 32'(notLoad), 32'hFF);
    chk("abort flags", 32'({flagC, flagZ}), 32'd0);
    chk("abort done_pc", 32'({done, pcInc}), 32'd0);
    repeat (2) @(negedge clock);
    notReset = 1'b1;
    @(negedge clock);
    chk("abort ready", 32'(cmdReady), 32'd1);
    chk("abort r3", 32'(regs[3]), 32'h5555);
    chk("abort notOE2", 32'(notOE), 32'hFF);

    // Back-to-back binary ADDs with cmdValid held: one acceptance every 4 cycles
    preload(3'd1, 16'h0003); preload(3'd2, 16'h0005);
    @(negedge clock);
    cmdValid = 1'b1; cmdOp = 4'd1; cmdSrcA = 3'd1; cmdSrcB = 3'd2; cmdDst = 3'd3;
    na = 0;
    for (int k = 0; k < 12; k++) begin
      if (cmdReady && na < 4) begin acc[na] = k; na++; end
      @(negedge clock);
    end
    cmdValid = 1'b0;
    repeat (2) @(negedge clock);
    chk("tput count", 32'(na), 32'd3);
    chk("tput gap1", 32'(acc[1] - acc[0]), 32'd4);
    chk("tput gap2", 32'(acc[2] - acc[1]), 32'd4);
    chk("tput r3", 32'(regs[3]), 32'h0008);
    chk("tput flags", 32'({flagC, flagZ}), 32'd0);

    // Random commands against the reference model
    for (int i = 0; i < 8; i++) begin
      mr[i] = rnd_val();
      preload(3'(i), mr[i]);
    end
    do_check("rnd_init", 4'd5, 3'd0, 3'd0, 3'd0, 16'h0000, 1'b0, 1'b1);
    mr[0] = 16'h0000; mc = 1'b0; mz = 1'b1;
    for (int n = 0; n < 150; n++) begin
      op = 4'($urandom_range(0, 15));
      sa = 3'($urandom); sb = 3'($urandom); d = 3'($urandom);
      if ($urandom_range(0, 3) == 0) begin
        mr[sa] = rnd_val();
        preload(sa, mr[sa]);
      end
      c2 = mc; z2 = mz;
      ref_alu(int'(op), int'(mr[sa]), int'(mr[sb]), c2, z2, y);
      do_check($sformatf("rnd%0d op%0d", n, op), op, sa, sb, d, 16'(y), c2, z2);
      mr[d] = 16'(y); mc = c2; mz = z2;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
